tmds_serializer_diff: RTL and testbench
=======================================

TMDS_SERIALIZER_DIFF -- requirements
Module: tmds_serializer_diff

Interface
REQ-001 SHALL have parameter C_channels, default 4, number of output lanes (index C_channels-1 is the clock lane by convention).
REQ-002 SHALL have parameter C_bits, default 10, symbol width per lane.
REQ-003 SHALL have parameter C_ddr, default 1'b0: 0 selects SDR (1 bit/cycle), 1 selects DDR (2 bits/cycle via ODDRX1F).
REQ-004 SHALL have parameter C_idle_word, default 10'b1101010100, symbol substituted on underflow.
REQ-005 SHALL have parameter C_invert, default 0, C_channels-bit mask; bit i set swaps p/n data polarity of lane i.
REQ-006 SHALL have port clk_shift  input  1  bit/shift clock; all state on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port in_word  input  C_channels*C_bits  parallel symbols, lane i at [i*C_bits +: C_bits].
REQ-009 SHALL have port in_valid  input  1  in_word holds a valid symbol set.
REQ-010 SHALL have port in_ready  output  1  registered; high for exactly the cycle in which in_word is sampled.
REQ-011 SHALL have port enable  input  1  0 forces outputs to idle levels.
REQ-012 SHALL have port clr_underflow  input  1  clears sticky underflow.
REQ-013 SHALL have port underflow  output  1  sticky: a load found in_valid low while enable high.
REQ-014 SHALL have ports out_p and out_n  output  C_channels each  fake-differential lane outputs.

Function
REQ-015 SHALL define L = C_bits when C_ddr=0, C_bits/2 when C_ddr=1; C_ddr=1 with odd C_bits is a configuration error (elaboration fail).
REQ-016 SHALL run a phase counter 0..L-1, incrementing every cycle, wrapping L-1 -> 0, never stalling.
REQ-017 SHALL assert in_ready in the cycle where counter == L-1, deasserted otherwise.
REQ-018 SHALL, at the edge ending a counter == L-1 cycle (load edge), load each lane shift register with its in_word slice if in_valid, else with C_idle_word for every lane.
REQ-019 SHALL, at every non-load edge, shift each lane register right by 1 (SDR) or 2 (DDR), LSB transmitted first.
REQ-020 SHALL register per lane at every edge: p-bits = shift[0] (SDR) or shift[1:0] (DDR, D0=bit0, D1=bit1) XOR C_invert[i]; n-bits = bitwise complement of p-bits.
REQ-021 SHALL drive out_p/out_n directly from the SDR register bit 0, or through one ODDRX1F each for p and n in DDR (SCLK=clk_shift, RST=~rst_n).
REQ-022 SHALL give latency: symbol bit j loaded at load edge k appears at the output register after edge k+1+j (SDR) or, as pair (2j, 2j+1), after edge k+1+j (DDR, measured at ODDRX1F D0/D1).
REQ-023 SHALL, while enable=0, force output-register p-bits to 0 and n-bits to 1 regardless of C_invert; counter, in_ready and loads continue; consumed words are discarded.
REQ-024 SHALL set underflow at a load edge with in_valid=0 and enable=1; clr_underflow clears it; simultaneous set and clear -> set wins.
REQ-025 SHALL apply enable and in_valid changes only at edges; an enable rising mid-symbol resumes output at the next edge from the current shift-register contents.

Reset
REQ-026 SHALL, while rst_n=0, hold counter=0, every shift register=C_idle_word, in_ready=0, underflow=0, output-register p-bits=0, n-bits=1.
REQ-027 SHALL, after rst_n release, raise in_ready in cycle L-1 (first load at edge L), idle symbol transmitted until then; reset asserted mid-symbol aborts immediately.

Verification
REQ-028 SHALL cover SDR, C_channels=4, in_valid=1, lane0 word 10'h2AA -> out_p[0] sequence 0,1,0,1,... after load edge k+1, out_n[0] complemented, in_ready period 10.
REQ-029 SHALL cover DDR, word 10'b0000011111 -> D0/D1 pairs (1,1),(1,1),(1,0),(0,0),(0,0), in_ready period 5.
REQ-030 SHALL cover in_valid=0 at one load, enable=1 -> all lanes send 10'b1101010100, underflow=1 sticky until clr_underflow; set+clear same edge -> stays 1.
REQ-031 SHALL cover C_invert=4'b0001 -> lane0 out_p equals the uninverted out_n of lane 1 for the same word; enable=0 -> all out_p=0, out_n=1.
REQ-032 SHALL cover rst_n asserted mid-symbol (counter=4) -> immediate out_p=0, out_n=1, in_ready=0; after release first in_ready in cycle L-1.

Source files
------------

// File: rtl/tmds_serializer_diff.sv
// TMDS-style parallel-to-serial lane driver with fake-differential outputs.
// SDR emits one bit per clk_shift cycle; DDR emits two through ODDRX1F.
module tmds_serializer_diff #(
  parameter int unsigned           C_channels  = 4,
  parameter int unsigned           C_bits      = 10,
  parameter bit                    C_ddr       = 1'b0,
  parameter logic [C_bits-1:0]     C_idle_word = 10'b1101010100,
  parameter logic [C_channels-1:0] C_invert    = '0
) (
  input  logic                         clk_shift,
  input  logic                         rst_n,
  input  logic [C_channels*C_bits-1:0] in_word,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         enable,
  input  logic                         clr_underflow,
  output logic                         underflow,
  output logic [C_channels-1:0]        out_p,
  output logic [C_channels-1:0]        out_n
);

  localparam int unsigned L  = C_ddr ? C_bits / 2 : C_bits;
  localparam int unsigned SW = C_ddr ? 2 : 1;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  if (C_ddr && (C_bits % 2 != 0)) begin : g_cfg_err
    $error("tmds_serializer_diff: DDR mode requires an even C_bits");
  end

  logic [CW-1:0]                          r_cnt;
  logic [CW-1:0]                          w_cnt_next;
  logic                                   w_load;
  logic                                   r_ready;
  logic                                   r_underflow;
  logic [C_channels-1:0][C_bits-1:0]      r_sh;
  logic [C_channels-1:0][C_bits-1:0]      w_in;
  logic [C_channels-1:0][SW-1:0]          w_pbits;
  logic [C_channels-1:0][SW-1:0]          r_p;
  logic [C_channels-1:0][SW-1:0]          r_n;

  assign w_in = in_word;

  always_comb begin
    w_load     = (r_cnt == LAST);
    w_cnt_next = w_load ? '0 : r_cnt + CW'(1);
    w_pbits    = '0;
    for (int unsigned i = 0; i < C_channels; i++) begin
      w_pbits[i] = r_sh[i][SW-1:0] ^ {SW{C_invert[i]}};
    end
  end

  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_underflow <= 1'b0;
      r_sh        <= {C_channels{C_idle_word}};
      r_p         <= '0;
      r_n         <= '1;
    end else begin
      r_cnt   <= w_cnt_next;
      // in_ready is registered, so it is derived from the upcoming count
      r_ready <= (w_cnt_next == LAST);
      if (w_load && !in_valid && enable) begin
        r_underflow <= 1'b1;
      end else if (clr_underflow) begin
        r_underflow <= 1'b0;
      end
      for (int unsigned i = 0; i < C_channels; i++) begin
        if (w_load) begin
          r_sh[i] <= in_valid ? w_in[i] : C_idle_word;
        end else begin
          r_sh[i] <= r_sh[i] >> SW;
        end
        r_p[i] <= enable ? w_pbits[i]  : '0;
        r_n[i] <= enable ? ~w_pbits[i] : '1;
      end
    end
  end

  assign in_ready  = r_ready;
  assign underflow = r_underflow;

  for (genvar g = 0; g < C_channels; g++) begin : g_lane
    if (!C_ddr) begin : g_sdr
      assign out_p[g] = r_p[g][0];
      assign out_n[g] = r_n[g][0];
    end else begin : g_ddr
      ODDRX1F u_oddr_p (
        .D0   (r_p[g][0]),
        .D1   (r_p[g][SW-1]),
        .SCLK (clk_shift),
        .RST  (~rst_n),
        .Q    (out_p[g])
      );
      ODDRX1F u_oddr_n (
        .D0   (r_n[g][0]),
        .D1   (r_n[g][SW-1]),
        .SCLK (clk_shift),
        .RST  (~rst_n),
        .Q    (out_n[g])
      );
    end
  end

endmodule

// Behavioural stand-in for the ECP5 ODDRX1F primitive; remove when the
// vendor cell library provides it. D0 drives the high phase, D1 the low phase.
module ODDRX1F (
  input  logic D0,
  input  logic D1,
  input  logic SCLK,
  input  logic RST,
  output logic Q
);

  logic r_d0;
  logic r_d1;

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      r_d0 <= 1'b0;
      r_d1 <= 1'b0;
    end else begin
      r_d0 <= D0;
      r_d1 <= D1;
    end
  end

  assign Q = SCLK ? r_d0 : r_d1;

endmodule

// File: tb/tb_tmds_serializer_diff.sv
// Directed bench for tmds_serializer_diff: SDR, DDR and lane-inverted instances
// share one stimulus set and are checked against hand-derived bit sequences.
module tb_tmds_serializer_diff;

  localparam logic [9:0] IDLE = 10'b1101010100;

  logic        clk;
  logic        rst_n;
  logic [39:0] in_word;
  logic        in_valid;
  logic        enable;
  logic        clr;

  logic       s_ready, s_uf, d_ready, d_uf, v_ready, v_uf;
  logic [3:0] s_p, s_n, d_p, d_n, v_p, v_n;

  int checks = 0;
  int errors = 0;

  tmds_serializer_diff u_sdr (
    .clk_shift(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(s_ready), .enable(enable), .clr_underflow(clr),
    .underflow(s_uf), .out_p(s_p), .out_n(s_n)
  );

  tmds_serializer_diff #(.C_ddr(1'b1)) u_ddr (
    .clk_shift(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(d_ready), .enable(enable), .clr_underflow(clr),
    .underflow(d_uf), .out_p(d_p), .out_n(d_n)
  );

  tmds_serializer_diff #(.C_invert(4'b0001)) u_inv (
    .clk_shift(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(v_ready), .enable(enable), .clr_underflow(clr),
    .underflow(v_uf), .out_p(v_p), .out_n(v_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit ddr);
    int n;
    n = 0;
    while (((ddr ? d_ready : s_ready) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ((ddr ? d_ready : s_ready) !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready ddr=%0d: in_ready=%b, required 1 within 40 cycles",
               ddr, ddr ? d_ready : s_ready);
    end
  endtask

  task automatic test_reset();
    logic [9:0] idle;
    idle     = IDLE;
    rst_n    = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b1;
    clr      = 1'b0;
    in_word  = '0;
    #12;
    checks++;
    if ({s_p, s_n, s_ready, s_uf} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: p=%h n=%h ready=%b uf=%b, required p=0 n=f ready=0 uf=0",
               s_p, s_n, s_ready, s_uf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 1; m <= 9; m++) begin
      tick();
      checks++;
      if (s_ready !== (m == 9) || d_ready !== (m == 4 || m == 9)) begin
        errors++;
        $display("FAIL reset_ready cycle %0d: sdr=%b ddr=%b, required sdr=%b ddr=%b",
                 m, s_ready, d_ready, m == 9, m == 4 || m == 9);
      end
      checks++;
      if (s_p !== {4{idle[m-1]}} || s_n !== ~{4{idle[m-1]}} ||
          v_p !== {{3{idle[m-1]}}, ~idle[m-1]}) begin
        errors++;
        $display("FAIL reset_idle bit %0d: sdr p=%h n=%h inv p=%h, required bit %b on all lanes",
                 m - 1, s_p, s_n, v_p, idle[m-1]);
      end
    end
  endtask

  task automatic test_sdr_pattern();
    logic [9:0] w [4];
    logic [3:0] exp_p;
    w[0] = 10'h2AA; w[1] = 10'h0F3; w[2] = 10'h155; w[3] = 10'h3E0;
    in_word = {w[3], w[2], w[1], w[0]};
    wait_ready(1'b0);
    tick();
    for (int j = 0; j < 10; j++) begin
      tick();
      exp_p = {w[3][j], w[2][j], w[1][j], w[0][j]};
      checks++;
      if (s_p !== exp_p || s_n !== ~exp_p) begin
        errors++;
        $display("FAIL sdr_bit %0d: p=%h n=%h, required p=%h n=%h", j, s_p, s_n, exp_p, ~exp_p);
      end
      checks++;
      if (s_ready !== (j == 8)) begin
        errors++;
        $display("FAIL sdr_ready_period bit %0d: ready=%b, required %b", j, s_ready, j == 8);
      end
    end
  endtask

  task automatic test_ddr_pairs();
    logic [9:0] w;
    int n;
    w = 10'b0000011111;
    in_word = {30'h0, w};
    wait_ready(1'b1);
    tick();
    tick();
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (d_p[0] !== w[2*j] || d_n[0] !== ~w[2*j]) begin
        errors++;
        $display("FAIL ddr_d0 pair %0d: p=%b n=%b, required p=%b", j, d_p[0], d_n[0], w[2*j]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (d_p[0] !== w[2*j+1] || d_n[0] !== ~w[2*j+1]) begin
        errors++;
        $display("FAIL ddr_d1 pair %0d: p=%b n=%b, required p=%b", j, d_p[0], d_n[0], w[2*j+1]);
      end
    end
    wait_ready(1'b1);
    n = 0;
    do begin
      tick();
      n++;
    end while (d_ready !== 1'b1 && n < 20);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ddr_ready_period: %0d cycles, required 5", n);
    end
  endtask

  task automatic test_underflow();
    logic [9:0] idle;
    idle = IDLE;
    in_word = {10'h3E0, 10'h155, 10'h0F3, 10'h2AA};
    wait_ready(1'b0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    checks++;
    if (s_uf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: underflow=%b, required 1", s_uf);
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (s_p !== {4{idle[j]}} || s_n !== ~{4{idle[j]}}) begin
        errors++;
        $display("FAIL underflow_idle bit %0d: p=%h n=%h, required p=%h",
                 j, s_p, s_n, {4{idle[j]}});
      end
    end
    checks++;
    if (s_uf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: underflow=%b, required 1", s_uf);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (s_uf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: underflow=%b, required 0", s_uf);
    end
    wait_ready(1'b0);
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    in_valid = 1'b1;
    checks++;
    if (s_uf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set_wins: underflow=%b, required 1", s_uf);
    end
    tick();
    clr = 1'b0;
    checks++;
    if (s_uf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear_after: underflow=%b, required 0", s_uf);
    end
  endtask

  task automatic test_invert();
    logic [9:0] w;
    w = 10'h2C5;
    in_word = {10'h000, 10'h3FF, w, w};
    wait_ready(1'b0);
    tick();
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (v_p[1:0] !== {w[j], ~w[j]} || v_n[1:0] !== {~w[j], w[j]} || v_p[0] !== v_n[1]) begin
        errors++;
        $display("FAIL invert bit %0d: p=%b n=%b, required p=%b n=%b",
                 j, v_p[1:0], v_n[1:0], {w[j], ~w[j]}, {~w[j], w[j]});
      end
    end
  endtask

  task automatic test_enable();
    logic [9:0] w;
    w = 10'h1B4;
    enable = 1'b0;
    tick();
    checks++;
    if ({s_p, s_n, v_p, v_n} !== {4'h0, 4'hF, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL enable_off: sdr p=%h n=%h inv p=%h n=%h, required p=0 n=f",
               s_p, s_n, v_p, v_n);
    end
    wait_ready(1'b0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    checks++;
    if (s_uf !== 1'b0 || s_p !== 4'h0 || s_n !== 4'hF) begin
      errors++;
      $display("FAIL enable_off_load: uf=%b p=%h n=%h, required uf=0 p=0 n=f", s_uf, s_p, s_n);
    end
    checks++;
    if (d_p !== 4'h0 || d_n !== 4'hF) begin
      errors++;
      $display("FAIL enable_off_ddr_hi: p=%h n=%h, required p=0 n=f", d_p, d_n);
    end
    @(negedge clk);
    #1;
    checks++;
    if (d_p !== 4'h0 || d_n !== 4'hF) begin
      errors++;
      $display("FAIL enable_off_ddr_lo: p=%h n=%h, required p=0 n=f", d_p, d_n);
    end
    in_word = {30'h0, w};
    wait_ready(1'b0);
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (s_p[0] !== 1'b0 || s_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_held_off: p=%b n=%b, required p=0 n=1", s_p[0], s_n[0]);
    end
    enable = 1'b1;
    for (int j = 3; j < 6; j++) begin
      tick();
      checks++;
      if (s_p[0] !== w[j] || s_n[0] !== ~w[j]) begin
        errors++;
        $display("FAIL enable_resume bit %0d: p=%b n=%b, required p=%b", j, s_p[0], s_n[0], w[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_ready(1'b0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int m = 0; m < 4; m++) tick();
    checks++;
    if (s_uf !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_uf: underflow=%b, required 1", s_uf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_p, s_n, s_ready, s_uf, v_p, v_n} !== {4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_mid: p=%h n=%h ready=%b uf=%b inv p=%h n=%h, required p=0 n=f ready=0 uf=0",
               s_p, s_n, s_ready, s_uf, v_p, v_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 1; m <= 10; m++) begin
      tick();
      checks++;
      if (s_ready !== (m == 9)) begin
        errors++;
        $display("FAIL reset_mid_ready cycle %0d: ready=%b, required %b", m, s_ready, m == 9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sdr_pattern();
    test_ddr_pairs();
    test_underflow();
    test_invert();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
